timer_delay_scheduler: RTL and testbench

Shares one interval-timer peripheral (16-bit Avalon-MM slave with stop/period/start/status registers) among NUM_REQ hardware requesters that each need a one-shot delay. Round-robin arbitration picks a requester. The block then sequences the register writes: stop, period, start. It waits for the timer's irq, clears the timer status, and pulses done back to the requester. It sits between the requesting blocks and the timer's s1 slave port, in place of a CPU driver.

---
 rtl/timer_delay_scheduler_if.sv | 39 +++
 rtl/timer_delay_scheduler.sv | 157 +++++++++++++++
 tb/tb_timer_delay_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_delay_scheduler_if.sv
// Requester-side and timer-side signals of timer_delay_scheduler; master = scheduler view, slave = environment view.
// The abort port only exists when TIMER_SCHED_ABORT_EN is defined.
interface timer_delay_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int TICK_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TICK_W-1:0] req_ticks;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic [ID_W-1:0]           active_id;
  logic [3:0]                avm_address;
  logic                      avm_chipselect;
  logic                      avm_write_n;
  logic [15:0]               avm_writedata;
  logic                      timer_irq;
`ifdef TIMER_SCHED_ABORT_EN
  logic [NUM_REQ-1:0]        abort;
`endif
  logic                      aborted;

  modport master (
    input  req, req_ticks, timer_irq,
`ifdef TIMER_SCHED_ABORT_EN
    input  abort,
`endif
    output done, busy, active_id, avm_address, avm_chipselect, avm_write_n, avm_writedata, aborted
  );

  modport slave (
    output req, req_ticks, timer_irq,
`ifdef TIMER_SCHED_ABORT_EN
    output abort,
`endif
    input  done, busy, active_id, avm_address, avm_chipselect, avm_write_n, avm_writedata, aborted
  );
endinterface

// File: rtl/timer_delay_scheduler.sv
// Round-robin sharing of one interval timer among NUM_REQ one-shot delay requesters; bus writes are registered
// from the next state, no preemption while busy. Optional cancel path under TIMER_SCHED_ABORT_EN.
module timer_delay_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TICK_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  timer_delay_scheduler_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_PER0, S_PER1, S_PER2, S_PER3, S_START, S_WAIT, S_CLEAR, S_DONE
`ifdef TIMER_SCHED_ABORT_EN
    , S_ABORT
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     active_q, active_nxt, last_grant, grant_id, cand;
  logic [TICK_W-1:0]   ticks_q, ticks_nxt, sel_ticks;
  logic [63:0]         load;
  logic                any_req;
  logic                wr_d, busy_d;
  logic [3:0]          addr_d;
  logic [15:0]         wdata_d;
  logic [NUM_REQ-1:0]  done_d;

  assign any_req = |bus.req;

  // Lowest offset from last_grant+1 wins, so the loop walks offsets downwards.
  always_comb begin
    grant_id = last_grant;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(last_grant) + i + 1) % NUM_REQ);
      if (bus.req[cand]) grant_id = cand;
    end
  end

  always_comb begin
    sel_ticks = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_id == ID_W'(i)) sel_ticks = bus.req_ticks[i*TICK_W +: TICK_W];
  end

  always_comb begin
    ticks_nxt  = ticks_q;
    active_nxt = active_q;
    if (state == S_IDLE && any_req) begin
      ticks_nxt  = sel_ticks;
      active_nxt = grant_id;
    end
  end

  assign load = 64'(ticks_nxt - TICK_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ticks_q    <= '0;
      active_q   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      state    <= state_nxt;
      ticks_q  <= ticks_nxt;
      active_q <= active_nxt;
      if (state == S_DONE) last_grant <= active_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_STOP;
      S_STOP:  state_nxt = (ticks_q == '0) ? S_DONE : S_PER0;
      S_PER0:  state_nxt = S_PER1;
      S_PER1:  state_nxt = S_PER2;
      S_PER2:  state_nxt = S_PER3;
      S_PER3:  state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (bus.timer_irq) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
`ifdef TIMER_SCHED_ABORT_EN
      S_ABORT: state_nxt = S_CLEAR;
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef TIMER_SCHED_ABORT_EN
    // A timeout arriving together with the cancel takes priority.
    if (bus.abort[active_q] && !(state == S_WAIT && bus.timer_irq) &&
        (state inside {S_PER0, S_PER1, S_PER2, S_PER3, S_START, S_WAIT}))
      state_nxt = S_ABORT;
`endif
  end

  always_comb begin
    wr_d    = 1'b0;
    addr_d  = 4'd0;
    wdata_d = 16'h0000;
    done_d  = '0;
    busy_d  = (state_nxt != S_IDLE);
    case (state_nxt)
      S_STOP:  if (ticks_nxt != '0) begin wr_d = 1'b1; addr_d = 4'd1; wdata_d = 16'h0008; end
      S_PER0:  begin wr_d = 1'b1; addr_d = 4'd2; wdata_d = load[15:0];  end
      S_PER1:  begin wr_d = 1'b1; addr_d = 4'd3; wdata_d = load[31:16]; end
      S_PER2:  begin wr_d = 1'b1; addr_d = 4'd4; wdata_d = load[47:32]; end
      S_PER3:  begin wr_d = 1'b1; addr_d = 4'd5; wdata_d = load[63:48]; end
      S_START: begin wr_d = 1'b1; addr_d = 4'd1; wdata_d = 16'h0005;    end
      S_CLEAR: begin wr_d = 1'b1; addr_d = 4'd0; wdata_d = 16'h0000;    end
      S_DONE:  done_d[active_nxt] = 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
      S_ABORT: begin wr_d = 1'b1; addr_d = 4'd1; wdata_d = 16'h0008;    end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.done           <= '0;
      bus.busy           <= 1'b0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_address    <= 4'd0;
      bus.avm_writedata  <= 16'h0000;
    end else begin
      bus.done           <= done_d;
      bus.busy           <= busy_d;
      bus.avm_chipselect <= wr_d;
      bus.avm_write_n    <= !wr_d;
      bus.avm_address    <= addr_d;
      bus.avm_writedata  <= wdata_d;
    end
  end

  assign bus.active_id = active_q;

`ifdef TIMER_SCHED_ABORT_EN
  logic aborted_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aborted_q   <= 1'b0;
      bus.aborted <= 1'b0;
    end else begin
      if (state_nxt == S_ABORT)     aborted_q <= 1'b1;
      else if (state_nxt == S_IDLE) aborted_q <= 1'b0;
      bus.aborted <= (state_nxt == S_DONE) && aborted_q;
    end
  end
`else
  assign bus.aborted = 1'b0;
`endif
endmodule

// File: tb/tb_timer_delay_scheduler.sv
// Bench for timer_delay_scheduler: behavioural interval timer, bus monitor and a round-robin/write-list reference model.
// Directed and randomized request patterns; abort scenario only when TIMER_SCHED_ABORT_EN is defined.
module tb_timer_delay_scheduler;
  localparam int NR = 4;
  localparam int TW = 32;
  typedef logic [TW-1:0] tk_t [NR];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_grant_m = NR - 1;

  timer_delay_scheduler_if #(.NUM_REQ(NR), .TICK_W(TW)) bus ();
  timer_delay_scheduler #(.NUM_REQ(NR), .TICK_W(TW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Interval timer: control bit0 ITO, bit2 START, bit3 STOP; one-shot countdown of period+1 cycles.
  logic [63:0] t_per, t_cnt;
  logic        t_run, t_to, t_ito;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_per <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
        else t_cnt <= t_cnt - 64'd1;
      end
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        case (bus.avm_address)
          4'd0: t_to <= 1'b0;
          4'd1: begin
            t_ito <= bus.avm_writedata[0];
            if (bus.avm_writedata[3]) t_run <= 1'b0;
            if (bus.avm_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
          end
          4'd2: t_per[15:0]  <= bus.avm_writedata;
          4'd3: t_per[31:16] <= bus.avm_writedata;
          4'd4: t_per[47:32] <= bus.avm_writedata;
          4'd5: t_per[63:48] <= bus.avm_writedata;
          default: ;
        endcase
      end
    end
  end
  assign bus.timer_irq = t_to & t_ito;

  int          w_cyc[$];
  int          w_a[$];
  logic [15:0] w_d[$];
  int          done_cyc[$];
  int          done_id[$];
  logic        done_ab[$];
  int          irq_q[$];
  logic        irq_prev = 1'b0;
  int          exp_a[$];
  logic [15:0] exp_d[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        w_cyc.push_back(cyc); w_a.push_back(int'(bus.avm_address)); w_d.push_back(bus.avm_writedata);
      end
      for (int i = 0; i < NR; i++)
        if (bus.done[i]) begin done_cyc.push_back(cyc); done_id.push_back(i); done_ab.push_back(bus.aborted); end
      if (bus.timer_irq && !irq_prev) irq_q.push_back(cyc);
    end
    irq_prev = bus.timer_irq;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (done_cyc.size() < n && t < budget) begin tick(); t++; end
    ok = (done_cyc.size() >= n);
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (w_cyc.size() < n && t < budget) begin tick(); t++; end
    ok = (w_cyc.size() >= n);
  endtask

  // Expected timer register writes for one delay of t cycles, CLEAR included.
  function automatic void add_exp(input logic [TW-1:0] t);
    logic [63:0] l;
    exp_a.delete(); exp_d.delete();
    if (t == 0) return;
    l = {32'h0, t} - 64'd1;
    exp_a.push_back(1); exp_d.push_back(16'h0008);
    exp_a.push_back(2); exp_d.push_back(l[15:0]);
    exp_a.push_back(3); exp_d.push_back(l[31:16]);
    exp_a.push_back(4); exp_d.push_back(l[47:32]);
    exp_a.push_back(5); exp_d.push_back(l[63:48]);
    exp_a.push_back(1); exp_d.push_back(16'h0005);
    exp_a.push_back(0); exp_d.push_back(16'h0000);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_active_id"}, bus.active_id, 0);
    chk({tag, "_cs"}, bus.avm_chipselect, 0);
    chk({tag, "_write_n"}, bus.avm_write_n, 1);
    chk({tag, "_addr"}, bus.avm_address, 0);
    chk({tag, "_wdata"}, bus.avm_writedata, 0);
    chk({tag, "_aborted"}, bus.aborted, 0);
  endtask

  // Drive a request mask, let every requester finish, and compare order, writes and timing with the model.
  task automatic run(input logic [NR-1:0] mask, input tk_t tk);
    int order[$];
    logic [NR-1:0] m;
    int lg, w0, d0, i0, k, wi, ii, maxt, base, id, dl;
    bit ok;
    m = mask; lg = last_grant_m; maxt = 0;
    while (m != 0) begin
      for (int s = 1; s <= NR; s++) begin
        int c;
        c = (lg + s) % NR;
        if (m[c]) begin order.push_back(c); m[c] = 1'b0; lg = c; break; end
      end
    end
    for (int i = 0; i < NR; i++) if (int'(tk[i]) > maxt) maxt = int'(tk[i]);
    w0 = w_cyc.size(); d0 = done_cyc.size(); i0 = irq_q.size();
    for (int i = 0; i < NR; i++) bus.req_ticks[i*TW +: TW] = tk[i];
    bus.req = mask;
    k = cyc;
    for (int j = 0; j < order.size(); j++) begin
      wait_done(d0 + j + 1, maxt + 200, ok);
      chk("done_timeout", ok, 1);
      if (!ok) break;
      bus.req[done_id[d0+j]] = 1'b0;
    end
    bus.req = '0;
    tick(); tick();
    chk("busy_after", bus.busy, 0);
    chk("done_count", done_cyc.size() - d0, order.size());
    wi = w0; ii = i0;
    for (int j = 0; j < order.size(); j++) begin
      if (d0 + j >= done_cyc.size()) break;
      id = order[j];
      base = (j == 0) ? k : done_cyc[d0+j-1] + 1;
      chk("done_id", done_id[d0+j], id);
      chk("done_aborted", done_ab[d0+j], 0);
      if (tk[id] == 0) begin
        chk("zero_done_cyc", done_cyc[d0+j], base + 2);
      end else begin
        add_exp(tk[id]);
        chk("writes_present", (w_cyc.size() >= wi + 7) && (irq_q.size() > ii), 1);
        if (w_cyc.size() < wi + 7 || irq_q.size() <= ii) break;
        for (int e = 0; e < 7; e++) begin
          chk("wr_addr", w_a[wi+e], exp_a[e]);
          chk("wr_data", w_d[wi+e], exp_d[e]);
        end
        for (int e = 0; e < 6; e++) chk("setup_cyc", w_cyc[wi+e], base + 1 + e);
        dl = irq_q[ii] - w_cyc[wi+5];
        chk("irq_delay", (dl >= int'(tk[id]) - 2) && (dl <= int'(tk[id]) + 2), 1);
        chk("clear_cyc", w_cyc[wi+6], irq_q[ii] + 1);
        chk("done_cyc", done_cyc[d0+j], w_cyc[wi+6] + 1);
        wi += 7; ii++;
      end
    end
    chk("total_writes", w_cyc.size(), wi);
    if (order.size() > 0) last_grant_m = order[order.size()-1];
  endtask

  initial begin
    tk_t tv;
    bit ok;
    int w0;
    bus.req = '0;
    bus.req_ticks = '0;
`ifdef TIMER_SCHED_ABORT_EN
    bus.abort = '0;
`endif
    reset_n = 1'b0;
    tick(); tick(); tick();
    check_reset("reset");
    reset_n = 1'b1;
    tick();

    tv = '{100, 0, 0, 0};
    run(4'b0001, tv);

    tv = '{10, 10, 10, 10};
    run(4'b1111, tv);

    tv = '{0, 0, 0, 0};
    run(4'b0100, tv);

    for (int r = 0; r < 6; r++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++)
        tv[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      run(m, tv);
    end

    // Reset while waiting for the timer, then restart with requester 1 first.
    w0 = w_cyc.size();
    bus.req_ticks[1*TW +: TW] = 200;
    bus.req = 4'b0010;
    wait_writes(w0 + 6, 50, ok);
    chk("rst_reach_wait", ok, 1);
    repeat (10) tick();
    chk("rst_busy_pre", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    bus.req = '0;
    tick(); tick();
    reset_n = 1'b1;
    last_grant_m = NR - 1;
    tick();
    tv = '{0, 20, 5, 0};
    run(4'b0110, tv);

    tv = '{0, 0, 0, 32'h0001_0000};
    run(4'b1000, tv);

`ifdef TIMER_SCHED_ABORT_EN
    begin
      int d0, k, s, a;
      w0 = w_cyc.size(); d0 = done_cyc.size();
      bus.req_ticks[0 +: TW] = 1000;
      bus.req = 4'b0001;
      k = cyc;
      wait_writes(w0 + 6, 50, ok);
      chk("abort_reach_wait", ok, 1);
      if (ok) begin
        s = w_cyc[w0+5];
        while (cyc < s + 5) tick();
        bus.abort[0] = 1'b1;
        a = cyc;
        tick();
        bus.abort = '0;
        wait_done(d0 + 1, 100, ok);
        chk("abort_done_timeout", ok, 1);
        bus.req = '0;
        tick(); tick();
        chk("abort_writes", w_cyc.size(), w0 + 8);
        if (ok && w_cyc.size() == w0 + 8) begin
          chk("abort_wr_addr", w_a[w0+6], 1);
          chk("abort_wr_data", w_d[w0+6], 16'h0008);
          chk("abort_wr_cyc", w_cyc[w0+6], a + 1);
          chk("abort_clr_addr", w_a[w0+7], 0);
          chk("abort_clr_cyc", w_cyc[w0+7], a + 2);
          chk("abort_done_cyc", done_cyc[d0], a + 3);
          chk("abort_done_id", done_id[d0], 0);
          chk("abort_flag", done_ab[d0], 1);
          chk("abort_early", (done_cyc[d0] - k) < 1000, 1);
        end
      end
      bus.req = '0;
      last_grant_m = 0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
